byte_data_mem: RTL and testbench
================================

BYTE_DATA_MEM -- requirements
Module: byte_data_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: byte-address width.
REQ-002 SHALL have parameter DEPTH_BYTES, default 1024: capacity in bytes; multiple of 4, at most 2**ADDR_W.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts request
- req_wr  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load result
- rsp_err  out  1  request rejected
- init_done  out  1  memory clear complete

Function
REQ-004 SHALL store data little-endian: byte at addr+k maps to bits [8k+7:8k] of a word.
REQ-005 SHALL use FSM states INIT and RUN; INIT clears one 32-bit word per cycle, word 0 upward; after the last word (DEPTH_BYTES/4 cycles) -> RUN.
REQ-006 SHALL drive req_ready=1 and init_done=1 only in RUN.
REQ-007 SHALL accept a request on a cycle with req_valid && req_ready; no buffering; req_ready has no dependency on req_valid.
REQ-008 SHALL assert rsp_valid exactly one cycle after each accepted request, loads and stores alike, for exactly one cycle; full throughput of one request per cycle.
REQ-009 SHALL flag rsp_err with that rsp_valid on any of:
- half with addr[0]=1
- word with addr[1:0]!=0
- addr+size_bytes-1 >= DEPTH_BYTES
- req_size=11
REQ-010 SHALL leave memory unmodified on an erroring store, and return rsp_rdata=0 on an erroring load.
REQ-011 SHALL write only the addressed byte lanes on a store: byte -> wdata[7:0], half -> wdata[15:0], word -> all 32 bits.
REQ-012 SHALL return loads right-justified: byte/half extended to 32 bits per req_unsigned; word returned unmodified.
REQ-013 SHALL return rsp_rdata=0 for accepted stores.
REQ-014 SHALL hold rsp_rdata and rsp_err at their last response value while rsp_valid=0.
REQ-015 SHALL return newly written data for a load to the same address accepted the cycle after a store (no hazard).
REQ-016 SHALL ignore req_* inputs while in INIT.

Reset
REQ-017 SHALL, on rst_n=0 at a rising clk edge, enter INIT, set the clear pointer to 0, and set req_ready=0, init_done=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-018 SHALL, on reset mid-RUN, discard any pending response (no rsp_valid) and fully re-clear memory.
REQ-019 SHALL hold everything at its reset value while rst_n stays low.

Structure
REQ-020 SHALL put the size encodings (SIZE_B, SIZE_H, SIZE_W) and the state enum (INIT, RUN) in shared package byte_data_mem_pkg.
REQ-021 SHALL implement storage as four instances of sub-module byte_lane_ram: DEPTH_BYTES/4 x 8, one synchronous write port and one read port each.
REQ-022 SHALL keep alignment checks, lane-enable generation and load extension in the top module.

Verification
REQ-023 Reset, then count cycles -> init_done rises after exactly 256 cycles (defaults); a word load at 0x3FC returns 0x00000000.
REQ-024 Store word 0x80FF7F01 @0x010, then byte loads @0x010..0x013 signed -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; same loads unsigned -> 0x01, 0x7F, 0xFF, 0x80.
REQ-025 Store half 0xBEEF @0x022 over word 0x11223344 @0x020, then word load @0x020 -> 0xBEEF3344; half load @0x022 signed -> 0xFFFFBEEF.
REQ-026 Errors: word @0x006, half @0x101, word @0x3FE, size=11, and word @0x400 (checked with DEPTH_BYTES=1024, ADDR_W=12) -> each gives rsp_valid with rsp_err=1 and rsp_rdata=0; the prior content @0x004 is unchanged.
REQ-027 Back-to-back store 0xA5A5A5A5 @0x040 then load @0x040 on consecutive cycles -> second response is 0xA5A5A5A5; rsp_valid is high on two consecutive cycles.
REQ-028 Assert rst_n=0 in the cycle after a load is accepted -> no rsp_valid follows; re-INIT occurs; the previously written @0x040 reads back 0.

Source files
------------

// File: rtl/byte_data_mem_pkg.sv
// Shared size encodings, FSM states and helpers for the byte-addressable data memory.
package byte_data_mem_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_RSV = 2'b11
    } size_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Access length in bytes; the reserved encoding is rejected elsewhere.
    function automatic logic [2:0] size_bytes(input size_e size);
        case (size)
            SIZE_B:  size_bytes = 3'd1;
            SIZE_H:  size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // Byte-lane mask of an access whose first byte lands in lane 0.
    function automatic logic [3:0] base_lane_mask(input size_e size);
        case (size)
            SIZE_B:  base_lane_mask = 4'b0001;
            SIZE_H:  base_lane_mask = 4'b0011;
            default: base_lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/byte_data_mem_lane_ram.sv
// One 8-bit byte lane of the data memory: synchronous write, registered read.
module byte_lane_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        // Read data only moves on a read, so it holds between load responses.
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/byte_data_mem.sv
// Byte-addressable little-endian data memory with post-reset clear and one-cycle responses.
module byte_data_mem
    import byte_data_mem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DEPTH_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
    localparam int WORD_AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WORD_AW-1:0] LAST_WORD = WORD_AW'(DEPTH_WORDS - 1);
    localparam logic [ADDR_W:0]    LIMIT     = (ADDR_W + 1)'(DEPTH_BYTES);

    state_e               state_reg;
    logic [WORD_AW-1:0]   clr_ptr_reg;
    logic                 ready_reg;
    logic                 done_reg;

    logic                 rsp_valid_reg;
    logic                 rsp_err_reg;
    logic                 rsp_load_reg;
    size_e                rsp_size_reg;
    logic                 rsp_unsigned_reg;
    logic [1:0]           rsp_lane_reg;

    size_e                size;
    logic                 accept;
    logic                 misaligned;
    logic [ADDR_W:0]      end_addr;
    logic                 req_err;
    logic [WORD_AW-1:0]   word_idx;
    logic [3:0]           lane_mask;
    logic [31:0]          wdata_shifted;

    logic [3:0]           mem_we;
    logic [WORD_AW-1:0]   mem_waddr;
    logic [31:0]          mem_wdata;
    logic                 mem_re;
    logic [31:0]          ram_word;
    logic [31:0]          ram_shifted;
    logic [31:0]          load_data;

    assign size     = size_e'(req_size);
    // Gated with rst_n so a request seen during a mid-RUN reset is never accepted.
    assign accept   = req_valid && ready_reg && rst_n;
    assign word_idx = req_addr[WORD_AW+1:2];

    always_comb begin
        misaligned = 1'b0;
        case (size)
            SIZE_H:  misaligned = req_addr[0];
            SIZE_W:  misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        end_addr = {1'b0, req_addr} + (ADDR_W + 1)'(size_bytes(size)) - (ADDR_W + 1)'(1);
        req_err  = misaligned || (end_addr >= LIMIT) || (size == SIZE_RSV);
    end

    assign lane_mask     = base_lane_mask(size) << req_addr[1:0];
    assign wdata_shifted = req_wdata << {req_addr[1:0], 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= INIT;
            clr_ptr_reg <= '0;
            ready_reg   <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    if (clr_ptr_reg == LAST_WORD) begin
                        state_reg <= RUN;
                        ready_reg <= 1'b1;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_reg    <= 1'b0;
            rsp_err_reg      <= 1'b0;
            rsp_load_reg     <= 1'b0;
            rsp_size_reg     <= SIZE_B;
            rsp_unsigned_reg <= 1'b0;
            rsp_lane_reg     <= 2'b00;
        end else begin
            rsp_valid_reg <= accept;
            if (accept) begin
                rsp_err_reg      <= req_err;
                rsp_load_reg     <= !req_wr && !req_err;
                rsp_size_reg     <= size;
                rsp_unsigned_reg <= req_unsigned;
                rsp_lane_reg     <= req_addr[1:0];
            end
        end
    end

    // The clear sequence owns the write port in INIT; afterwards only good stores write.
    always_comb begin
        mem_we    = 4'b0000;
        mem_waddr = clr_ptr_reg;
        mem_wdata = 32'h0000_0000;
        if (rst_n && (state_reg == INIT)) begin
            mem_we = 4'b1111;
        end else if (accept && req_wr && !req_err) begin
            mem_we    = lane_mask;
            mem_waddr = word_idx;
            mem_wdata = wdata_shifted;
        end
    end

    assign mem_re = accept && !req_wr && !req_err;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            byte_lane_ram #(
                .DEPTH (DEPTH_WORDS),
                .AW    (WORD_AW)
            ) u_lane (
                .clk   (clk),
                .we    (mem_we[gi]),
                .waddr (mem_waddr),
                .wdata (mem_wdata[8*gi +: 8]),
                .re    (mem_re),
                .raddr (word_idx),
                .rdata (ram_word[8*gi +: 8])
            );
        end
    endgenerate

    always_comb begin
        ram_shifted = ram_word >> {rsp_lane_reg, 3'b000};
        load_data   = ram_shifted;
        case (rsp_size_reg)
            SIZE_B: load_data = rsp_unsigned_reg ? {24'h000000, ram_shifted[7:0]}
                                                 : {{24{ram_shifted[7]}}, ram_shifted[7:0]};
            SIZE_H: load_data = rsp_unsigned_reg ? {16'h0000, ram_shifted[15:0]}
                                                 : {{16{ram_shifted[15]}}, ram_shifted[15:0]};
            default: load_data = ram_shifted;
        endcase
    end

    assign req_ready = ready_reg;
    assign init_done = done_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_load_reg ? load_data : 32'h0000_0000;

endmodule

// File: tb/tb_byte_data_mem.sv
// Directed self-checking bench for byte_data_mem at default parameters.
module tb_byte_data_mem;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int total;
    int bad;

    byte_data_mem #(
        .ADDR_W      (12),
        .DEPTH_BYTES (1024)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_done    (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Presents one request for one edge, then samples the response 1 time unit later.
    task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          output logic v, output logic [31:0] d, output logic e);
        req_valid    = 1'b1;
        req_wr       = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        v = rsp_valid;
        d = rsp_rdata;
        e = rsp_err;
        req_valid = 1'b0;
        $display("req wr=%0b size=%0d uns=%0b addr=0x%03h wdata=0x%08h -> valid=%0b rdata=0x%08h err=%0b",
                 wr, size, uns, addr, wdata, v, d, e);
    endtask

    // Counts edges from reset release until init_done, with a store held on the bus throughout.
    task automatic wait_init(output int cycles, output int early_rsp);
        cycles    = 0;
        early_rsp = 0;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 12'h3FC;
        req_wdata = 32'hDEAD_BEEF;
        rst_n     = 1'b1;
        while (cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (rsp_valid) early_rsp++;
            if (init_done) break;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        int cycles;
        int early;
        logic v;
        logic e;
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({req_ready, init_done, rsp_valid, rsp_err} !== 4'b0000 || rsp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: ready=%0b done=%0b valid=%0b err=%0b rdata=0x%08h required all 0",
                     req_ready, init_done, rsp_valid, rsp_err, rsp_rdata);
        end
        wait_init(cycles, early);
        total++;
        if (cycles !== 256) begin
            bad++;
            $display("FAIL init_cycles: got %0d required 256", cycles);
        end
        total++;
        if (early !== 0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL init_ignores_req: early_rsp=%0d ready=%0b required 0 and 1", early, req_ready);
        end
        do_req(1'b0, 2'b10, 1'b0, 12'h3FC, 32'h0, v, d, e);
        total++;
        if (v !== 1'b1 || e !== 1'b0 || d !== 32'h0000_0000) begin
            bad++;
            $display("FAIL load_3fc_cleared: valid=%0b err=%0b rdata=0x%08h required 1 0 0x00000000", v, e, d);
        end
    endtask

    task automatic test_byte_loads();
        logic v;
        logic e;
        logic [31:0] d;
        logic [31:0] exp_s [4];
        logic [31:0] exp_u [4];
        exp_s = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
        exp_u = '{32'h0000_0001, 32'h0000_007F, 32'h0000_00FF, 32'h0000_0080};
        do_req(1'b1, 2'b10, 1'b0, 12'h010, 32'h80FF_7F01, v, d, e);
        total++;
        if (v !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin
            bad++;
            $display("FAIL store_word_rsp: valid=%0b err=%0b rdata=0x%08h required 1 0 0x00000000", v, e, d);
        end
        for (int k = 0; k < 4; k++) begin
            do_req(1'b0, 2'b00, 1'b0, 12'h010 + 12'(k), 32'h0, v, d, e);
            total++;
            if (v !== 1'b1 || e !== 1'b0 || d !== exp_s[k]) begin
                bad++;
                $display("FAIL byte_signed[%0d]: valid=%0b err=%0b rdata=0x%08h required 0x%08h", k, v, e, d, exp_s[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            do_req(1'b0, 2'b00, 1'b1, 12'h010 + 12'(k), 32'h0, v, d, e);
            total++;
            if (v !== 1'b1 || e !== 1'b0 || d !== exp_u[k]) begin
                bad++;
                $display("FAIL byte_unsigned[%0d]: valid=%0b err=%0b rdata=0x%08h required 0x%08h", k, v, e, d, exp_u[k]);
            end
        end
    endtask

    task automatic test_half_merge();
        logic v;
        logic e;
        logic [31:0] d;
        do_req(1'b1, 2'b10, 1'b0, 12'h020, 32'h1122_3344, v, d, e);
        do_req(1'b1, 2'b01, 1'b0, 12'h022, 32'h1234_BEEF, v, d, e);
        do_req(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, v, d, e);
        total++;
        if (d !== 32'hBEEF_3344 || e !== 1'b0) begin
            bad++;
            $display("FAIL half_merge_word: rdata=0x%08h err=%0b required 0xBEEF3344 0", d, e);
        end
        do_req(1'b0, 2'b01, 1'b0, 12'h022, 32'h0, v, d, e);
        total++;
        if (d !== 32'hFFFF_BEEF) begin
            bad++;
            $display("FAIL half_signed: rdata=0x%08h required 0xFFFFBEEF", d);
        end
        do_req(1'b0, 2'b01, 1'b1, 12'h020, 32'h0, v, d, e);
        total++;
        if (d !== 32'h0000_3344) begin
            bad++;
            $display("FAIL half_unsigned: rdata=0x%08h required 0x00003344", d);
        end
        do_req(1'b1, 2'b00, 1'b0, 12'h021, 32'hFFFF_FFAA, v, d, e);
        do_req(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, v, d, e);
        total++;
        if (d !== 32'hBEEF_AA44) begin
            bad++;
            $display("FAIL byte_lane_store: rdata=0x%08h required 0xBEEFAA44", d);
        end
    endtask

    task automatic test_errors();
        logic v;
        logic e;
        logic [31:0] d;
        logic        wr_t   [7];
        logic [1:0]  size_t [7];
        logic [11:0] addr_t [7];
        wr_t   = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1};
        size_t = '{2'b10,  2'b01,  2'b10,  2'b11,  2'b10,  2'b10,  2'b10};
        addr_t = '{12'h006, 12'h101, 12'h3FE, 12'h004, 12'h400, 12'h006, 12'h404};
        do_req(1'b1, 2'b10, 1'b0, 12'h004, 32'hCAFE_F00D, v, d, e);
        for (int k = 0; k < 7; k++) begin
            do_req(wr_t[k], size_t[k], 1'b0, addr_t[k], 32'h5555_5555, v, d, e);
            total++;
            if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
                bad++;
                $display("FAIL error_case[%0d]: valid=%0b err=%0b rdata=0x%08h required 1 1 0x00000000", k, v, e, d);
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL hold_err: valid=%0b err=%0b rdata=0x%08h required 0 1 0x00000000", rsp_valid, rsp_err, rsp_rdata);
        end
        do_req(1'b0, 2'b10, 1'b0, 12'h004, 32'h0, v, d, e);
        total++;
        if (v !== 1'b1 || e !== 1'b0 || d !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL error_no_write: valid=%0b err=%0b rdata=0x%08h required 1 0 0xCAFEF00D", v, e, d);
        end
        @(posedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL hold_data: valid=%0b err=%0b rdata=0x%08h required 0 0 0xCAFEF00D", rsp_valid, rsp_err, rsp_rdata);
        end
        do_req(1'b0, 2'b01, 1'b0, 12'h3FE, 32'h0, v, d, e);
        total++;
        if (v !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin
            bad++;
            $display("FAIL half_at_top: valid=%0b err=%0b rdata=0x%08h required 1 0 0x00000000", v, e, d);
        end
    endtask

    task automatic test_back_to_back();
        logic v1;
        logic v2;
        logic e;
        logic [31:0] d;
        do_req(1'b1, 2'b10, 1'b0, 12'h040, 32'hA5A5_A5A5, v1, d, e);
        do_req(1'b0, 2'b10, 1'b0, 12'h040, 32'h0, v2, d, e);
        total++;
        if (v1 !== 1'b1 || v2 !== 1'b1 || d !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL back_to_back: valid=%0b%0b rdata=0x%08h required 11 0xA5A5A5A5", v1, v2, d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        int cycles;
        int early;
        logic v;
        logic e;
        logic [31:0] d;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 12'h040;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0 || rsp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL mid_run_reset: valid=%0b ready=%0b done=%0b rdata=0x%08h required 0 0 0 0",
                     rsp_valid, req_ready, init_done, rsp_rdata);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        wait_init(cycles, early);
        total++;
        if (cycles !== 256 || early !== 0) begin
            bad++;
            $display("FAIL reinit: cycles=%0d early_rsp=%0d required 256 0", cycles, early);
        end
        do_req(1'b0, 2'b10, 1'b0, 12'h040, 32'h0, v, d, e);
        total++;
        if (v !== 1'b1 || d !== 32'h0) begin
            bad++;
            $display("FAIL reinit_cleared: valid=%0b rdata=0x%08h required 1 0x00000000", v, d);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_wr       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        test_reset();
        test_byte_loads();
        test_half_merge();
        test_errors();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
